// File: rtl/crc_pkg.sv
// Shared types, default CRC-32 constants and bit-reflection helpers for the CRC frame engine.
package crc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [31:0] CRC_POLY_DEFAULT = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT_DEFAULT = 32'hFFFFFFFF;

    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] reflect32(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[31-i];
        return r;
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational CRC-32 advance over N data bits, MSB of data_i shifted in first.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int          N    = 8,
    parameter logic [31:0] POLY = CRC_POLY_DEFAULT
) (
    input  logic [31:0]  crc_i,
    input  logic [N-1:0] data_i,
    output logic [31:0]  crc_o
);

    always_comb begin
        logic [31:0] c;
        logic        fb;
        c = crc_i;
        for (int i = N - 1; i >= 0; i--) begin
            fb = c[31] ^ data_i[i];
            c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        crc_o = c;
    end

endmodule

// File: rtl/crc_frame_engine.sv
// Framed CRC-32 engine with partial last beat; CRC_FRAME_CHECK_EN adds the expected-CRC compare on crc_err.
module crc_frame_engine
    import crc_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter logic [31:0] POLY    = CRC_POLY_DEFAULT,
    parameter logic [31:0] INIT    = CRC_INIT_DEFAULT,
    parameter logic [31:0] XOR_OUT = 32'h00000000,
    parameter bit          REFLECT = 1'b0,
    localparam int         NB      = DATA_W / 8,
    localparam int         NBW     = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [NBW-1:0]    din_nbytes,
    input  logic [DATA_W-1:0] din,
    input  logic [31:0]       exp_crc,
    output logic              crc_valid,
    output logic [31:0]       crc_out,
    output logic              crc_err,
    output logic              proto_err
);

    state_t            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [31:0]       crc_out_q, crc_out_d;
    logic              crc_valid_q, crc_valid_d;
    logic              proto_err_q, proto_err_d;
    logic              frame_done;
    logic [DATA_W-1:0] din_r;
    logic [31:0]       base_crc;
    logic [31:0]       step_crc [NB];
    logic [31:0]       step_sel;
    logic [31:0]       crc_fin;
    int                sel_int;

    // Reflected mode feeds each byte LSB-first into the MSB-first shifter.
    if (REFLECT) begin : g_refl
        for (genvar b = 0; b < NB; b++) begin : g_byte
            assign din_r[8*b +: 8] = reflect8(din[8*b +: 8]);
        end
        assign crc_fin = reflect32(step_sel) ^ XOR_OUT;
    end else begin : g_norefl
        assign din_r   = din;
        assign crc_fin = step_sel ^ XOR_OUT;
    end

    assign base_crc = din_sop ? INIT : crc_q;

    for (genvar g = 0; g < NB; g++) begin : g_step
        crc_lfsr_step #(.N(8 * (g + 1)), .POLY(POLY)) u_step (
            .crc_i  (base_crc),
            .data_i (din_r[DATA_W-1 -: 8*(g+1)]),
            .crc_o  (step_crc[g])
        );
    end

    always_comb begin
        sel_int  = (din_eop && din_nbytes != '0) ? int'(din_nbytes) - 1 : NB - 1;
        step_sel = step_crc[NB-1];
        for (int k = 0; k < NB; k++) begin
            if (k == sel_int) step_sel = step_crc[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        crc_out_d   = crc_out_q;
        crc_valid_d = 1'b0;
        proto_err_d = 1'b0;
        frame_done  = 1'b0;
        if (din_valid) begin
            if (din_sop || state_q == BUSY) begin
                crc_d       = step_sel;
                proto_err_d = din_sop && (state_q == BUSY);
                if (din_eop) begin
                    state_d     = IDLE;
                    frame_done  = 1'b1;
                    crc_out_d   = crc_fin;
                    crc_valid_d = 1'b1;
                end else begin
                    state_d = BUSY;
                end
            end else begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            crc_out_q   <= 32'h0;
            crc_valid_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            crc_out_q   <= crc_out_d;
            crc_valid_q <= crc_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign crc_valid = crc_valid_q;
    assign crc_out   = crc_out_q;
    assign proto_err = proto_err_q;

`ifdef CRC_FRAME_CHECK_EN
    logic crc_err_q, crc_err_d;

    always_comb begin
        crc_err_d = crc_err_q;
        if (frame_done) crc_err_d = (crc_fin != exp_crc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) crc_err_q <= 1'b0;
        else      crc_err_q <= crc_err_d;
    end

    assign crc_err = crc_err_q;
`else
    logic unused_check;
    assign unused_check = ^{exp_crc, frame_done};
    assign crc_err      = 1'b0;
`endif

endmodule

// File: tb/tb_crc_frame_engine.sv
// Directed bench: 32-bit reflected CRC-32, 8-bit and 64-bit CRC-32/MPEG-2 engines side by side.
module tb_crc_frame_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef CRC_FRAME_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        v32, s32, e32, cv32, ce32, pe32;
    logic [1:0]  nb32;
    logic [31:0] d32, x32, co32;

    logic        v8, s8, e8, cv8, ce8, pe8;
    logic        nb8;
    logic [7:0]  d8;
    logic [31:0] x8, co8;

    logic        v64, s64, e64, cv64, ce64, pe64;
    logic [2:0]  nb64;
    logic [63:0] d64;
    logic [31:0] x64, co64;

    crc_frame_engine #(.DATA_W(32), .REFLECT(1'b1), .XOR_OUT(32'hFFFFFFFF)) u_dut32 (
        .clk(clk), .rst(rst), .din_valid(v32), .din_sop(s32), .din_eop(e32),
        .din_nbytes(nb32), .din(d32), .exp_crc(x32),
        .crc_valid(cv32), .crc_out(co32), .crc_err(ce32), .proto_err(pe32)
    );

    crc_frame_engine #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .din_valid(v8), .din_sop(s8), .din_eop(e8),
        .din_nbytes(nb8), .din(d8), .exp_crc(x8),
        .crc_valid(cv8), .crc_out(co8), .crc_err(ce8), .proto_err(pe8)
    );

    crc_frame_engine #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .din_valid(v64), .din_sop(s64), .din_eop(e64),
        .din_nbytes(nb64), .din(d64), .exp_crc(x64),
        .crc_valid(cv64), .crc_out(co64), .crc_err(ce64), .proto_err(pe64)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cnt32  = 0;
    int cnt8   = 0;
    int cnt64  = 0;

    always @(negedge clk) begin
        if (cv32) cnt32++;
        if (cv8)  cnt8++;
        if (cv64) cnt64++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Byte-wise MSB-first CRC-32/MPEG-2 over the first nbytes of data.
    function automatic logic [31:0] ref_crc(input logic [63:0] data, input int nbytes);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int b = 0; b < nbytes; b++) begin
            c = c ^ {data[63-8*b -: 8], 24'h0};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        end
        return c;
    endfunction

    task automatic idle();
        @(negedge clk);
        v32 = 1'b0; v8 = 1'b0; v64 = 1'b0;
    endtask

    task automatic beat32(input logic s, input logic e, input logic [1:0] nb, input logic [31:0] d);
        @(negedge clk);
        v32 = 1'b1; s32 = s; e32 = e; nb32 = nb; d32 = d;
    endtask

    task automatic beat8(input logic s, input logic e, input logic nb, input logic [7:0] d);
        @(negedge clk);
        v8 = 1'b1; s8 = s; e8 = e; nb8 = nb; d8 = d;
    endtask

    task automatic beat64(input logic s, input logic e, input logic [2:0] nb, input logic [63:0] d);
        @(negedge clk);
        v64 = 1'b1; s64 = s; e64 = e; nb64 = nb; d64 = d;
    endtask

    task automatic frame_check32();
        beat32(1'b1, 1'b0, 2'd0, 32'h31323334);
        beat32(1'b0, 1'b0, 2'd0, 32'h35363738);
        beat32(1'b0, 1'b1, 2'd1, 32'h39AABBCC);
        idle();
    endtask

    initial begin
        rst = 1'b1;
        {v32, s32, e32, nb32, d32} = '0; x32 = 32'hCBF43926;
        {v8, s8, e8, nb8, d8}      = '0; x8  = 32'h0;
        {v64, s64, e64, nb64, d64} = '0; x64 = 32'h0;
        #2 rst = 1'b0;
        #10;
        check("rst_crc32",   co32, 0);
        check("rst_valid32", cv32, 0);
        check("rst_err32",   ce32, 0);
        check("rst_proto32", pe32, 0);
        check("rst_crc8",    co8,  0);
        check("rst_crc64",   co64, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // check frame, unused LSB bytes on the eop beat carry junk
        frame_check32();
        check("chk_valid", cv32, 1);
        check("chk_crc",   co32, 32'hCBF43926);
        check("chk_err",   ce32, 0);
        idle();
        check("chk_pulse", cv32, 0);
        check("chk_hold",  co32, 32'hCBF43926);

        // same frame with gaps and a wrong expected value
        x32 = 32'hCBF43927;
        beat32(1'b1, 1'b0, 2'd0, 32'h31323334);
        idle();
        beat32(1'b0, 1'b0, 2'd0, 32'h35363738);
        idle();
        idle();
        beat32(1'b0, 1'b1, 2'd1, 32'h39000000);
        idle();
        check("gap_valid", cv32, 1);
        check("gap_crc",   co32, 32'hCBF43926);
        check("bad_err",   ce32, EXP_ERR);
        x32 = 32'hCBF43926;

        // non-sop beat while idle
        beat32(1'b0, 1'b0, 2'd0, 32'hDEADBEEF);
        idle();
        check("idle_proto", pe32, 1);
        check("idle_nores", cv32, 0);
        check("idle_hold",  co32, 32'hCBF43926);
        idle();
        check("idle_proto_pulse", pe32, 0);

        // sop while busy abandons the open frame
        beat32(1'b1, 1'b0, 2'd0, 32'h41424344);
        beat32(1'b1, 1'b0, 2'd0, 32'h31323334);
        check("sop_first_proto", pe32, 0);
        beat32(1'b0, 1'b0, 2'd0, 32'h35363738);
        check("sop_busy_proto", pe32, 1);
        check("sop_busy_nores", cv32, 0);
        beat32(1'b0, 1'b1, 2'd1, 32'h39000000);
        check("sop_proto_pulse", pe32, 0);
        idle();
        check("restart_valid", cv32, 1);
        check("restart_crc",   co32, 32'hCBF43926);

        // reset on the middle beat
        beat32(1'b1, 1'b0, 2'd0, 32'h31323334);
        beat32(1'b0, 1'b0, 2'd0, 32'h35363738);
        #2 rst = 1'b0;
        #1;
        check("midrst_crc",   co32, 0);
        check("midrst_valid", cv32, 0);
        check("midrst_proto", pe32, 0);
        idle();
        rst = 1'b1;
        beat32(1'b0, 1'b1, 2'd1, 32'h39000000);
        idle();
        check("orphan_valid", cv32, 0);
        check("orphan_proto", pe32, 1);
        check("orphan_crc",   co32, 0);
        frame_check32();
        check("postrst_valid", cv32, 1);
        check("postrst_crc",   co32, 32'hCBF43926);

        // 8-bit "123456789" with a gap
        for (int i = 0; i < 9; i++) begin
            beat8(i == 0, i == 8, 1'b1, 8'h31 + 8'(i));
            if (i == 3) idle();
        end
        idle();
        check("b8_valid", cv8, 1);
        check("b8_crc",   co8, 32'h0376E6E7);
        check("b8_proto", pe8, 0);
        idle();
        check("b8_pulse", cv8, 0);

        // 64-bit back-to-back single-beat frames
        beat64(1'b1, 1'b1, 3'd0, 64'h0);
        beat64(1'b1, 1'b1, 3'd0, 64'hFFFFFFFFFFFFFFFF);
        check("b2b_valid0", cv64, 1);
        check("b2b_crc0",   co64, ref_crc(64'h0, 8));
        idle();
        check("b2b_valid1", cv64, 1);
        check("b2b_crc1",   co64, ref_crc(64'hFFFFFFFFFFFFFFFF, 8));
        check("b2b_proto",  pe64, 0);
        idle();
        check("b2b_pulse",  cv64, 0);

        // 64-bit partial last beat
        beat64(1'b1, 1'b0, 3'd0, 64'h3132333435363738);
        beat64(1'b0, 1'b1, 3'd1, 64'h39FFFFFFFFFFFFFF);
        idle();
        check("b64_part_valid", cv64, 1);
        check("b64_part_crc",   co64, 32'h0376E6E7);

        idle();
        check("count32", cnt32, 4);
        check("count8",  cnt8,  1);
        check("count64", cnt64, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
